// File: rtl/tawa_pkg.sv
// Shared constants, byte-slot enum and layout helpers for the T-format responder.
package tawa_pkg;

    // Fixed sync pattern in CF[2:0]
    localparam logic [2:0] CF_SYNC = 3'b010;

    // Data IDs carried in CF[6:3]
    localparam logic [3:0] ID_ABS      = 4'h0;
    localparam logic [3:0] ID_ABM      = 4'h1;
    localparam logic [3:0] ID_ENID     = 4'h2;
    localparam logic [3:0] ID_ALL      = 4'h3;
    localparam logic [3:0] ID_POS_RST  = 4'h7;
    localparam logic [3:0] ID_TURN_RST = 4'h8;
    localparam logic [3:0] ID_ERR_RST  = 4'hC;

    // Reply frame lengths in bytes, CRC included
    localparam logic [3:0] LEN_ENID = 4'd4;
    localparam logic [3:0] LEN_STD  = 4'd6;
    localparam logic [3:0] LEN_ALL  = 4'd11;

    typedef enum logic [3:0] {
        SLOT_CF,
        SLOT_SF,
        SLOT_ABS0,
        SLOT_ABS1,
        SLOT_ABS2,
        SLOT_ENID,
        SLOT_ABM0,
        SLOT_ABM1,
        SLOT_ABM2,
        SLOT_ALMF,
        SLOT_CRC
    } slot_e;

    function automatic logic id_supported(input logic [3:0] id);
        case (id)
            ID_ABS, ID_ABM, ID_ENID, ID_ALL,
            ID_POS_RST, ID_TURN_RST, ID_ERR_RST: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] frame_len(input logic [3:0] id);
        case (id)
            ID_ENID: return LEN_ENID;
            ID_ALL:  return LEN_ALL;
            default: return LEN_STD;
        endcase
    endfunction

    // Which field goes out at byte position idx of a reply to data ID id.
    // Anything past the payload maps to the CRC, so the CRC slot also
    // terminates the frame.
    function automatic slot_e slot_of(input logic [3:0] id, input logic [3:0] idx);
        slot_e s;
        s = SLOT_CRC;
        if (id == ID_ALL) begin
            case (idx)
                4'd0:    s = SLOT_CF;
                4'd1:    s = SLOT_SF;
                4'd2:    s = SLOT_ABS0;
                4'd3:    s = SLOT_ABS1;
                4'd4:    s = SLOT_ABS2;
                4'd5:    s = SLOT_ENID;
                4'd6:    s = SLOT_ABM0;
                4'd7:    s = SLOT_ABM1;
                4'd8:    s = SLOT_ABM2;
                4'd9:    s = SLOT_ALMF;
                default: s = SLOT_CRC;
            endcase
        end else if (id == ID_ENID) begin
            case (idx)
                4'd0:    s = SLOT_CF;
                4'd1:    s = SLOT_SF;
                4'd2:    s = SLOT_ENID;
                default: s = SLOT_CRC;
            endcase
        end else begin
            case (idx)
                4'd0:    s = SLOT_CF;
                4'd1:    s = SLOT_SF;
                4'd2:    s = (id == ID_ABM) ? SLOT_ABM0 : SLOT_ABS0;
                4'd3:    s = (id == ID_ABM) ? SLOT_ABM1 : SLOT_ABS1;
                4'd4:    s = (id == ID_ABM) ? SLOT_ABM2 : SLOT_ABS2;
                default: s = SLOT_CRC;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/tawa_cf_decode.sv
// Request (CF) decoder: checks sync/parity/ID, holds the accepted CF, ID and
// frame length, and produces the registered req_err and command pulses.
module tawa_cf_decode
    import tawa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       idle_i,
    output logic       accept_o,
    output logic [7:0] cf_o,
    output logic [3:0] id_o,
    output logic [3:0] len_o,
    output logic       req_err_o,
    output logic       cmd_pos_rst_o,
    output logic       cmd_turn_rst_o,
    output logic       cmd_err_rst_o
);

    logic [3:0] rx_id;
    logic       cf_ok;
    logic [7:0] cf_q;
    logic [3:0] id_q;
    logic [3:0] len_q;
    logic       req_err_q;
    logic       cmd_pos_rst_q;
    logic       cmd_turn_rst_q;
    logic       cmd_err_rst_q;

    assign rx_id    = rx_data_i[6:3];
    assign cf_ok    = (rx_data_i[2:0] == CF_SYNC) && (rx_data_i[7] == ^rx_id) && id_supported(rx_id);
    assign accept_o = rx_valid_i && idle_i && cf_ok;

    // Capture the accepted request and emit one-cycle status/command pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cf_q           <= 8'h00;
            id_q           <= 4'h0;
            len_q          <= 4'd0;
            req_err_q      <= 1'b0;
            cmd_pos_rst_q  <= 1'b0;
            cmd_turn_rst_q <= 1'b0;
            cmd_err_rst_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            req_err_q      <= rx_valid_i && idle_i && !cf_ok;
            cmd_pos_rst_q  <= accept_o && (rx_id == ID_POS_RST);
            cmd_turn_rst_q <= accept_o && (rx_id == ID_TURN_RST);
            cmd_err_rst_q  <= accept_o && (rx_id == ID_ERR_RST);
            if (accept_o) begin
                cf_q  <= rx_data_i;
                id_q  <= rx_id;
                len_q <= frame_len(rx_id);
            end
        end
    end

    assign cf_o           = cf_q;
    assign id_o           = id_q;
    assign len_o          = len_q;
    assign req_err_o      = req_err_q;
    assign cmd_pos_rst_o  = cmd_pos_rst_q;
    assign cmd_turn_rst_o = cmd_turn_rst_q;
    assign cmd_err_rst_o  = cmd_err_rst_q;

endmodule

// File: rtl/tawa_encoder_responder.sv
// Encoder-side T-format responder: accepts a CF request, snapshots the
// encoder fields and streams the reply frame byte by byte, ending in the CRC.
module tawa_encoder_responder
    import tawa_pkg::*;
#(
    parameter int         TURNAROUND_CYC = 16,
    parameter logic [7:0] ENID_VAL       = 8'h17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [23:0] pos_in,
    input  logic [23:0] turn_in,
    input  logic [7:0]  sf_in,
    input  logic [7:0]  alm_in,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        req_err,
    output logic        drop,
    output logic        cmd_pos_rst,
    output logic        cmd_turn_rst,
    output logic        cmd_err_rst,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    // WAIT always lasts TURNAROUND_CYC + 1 cycles: the decode cycle plus the idle gap
    localparam int                CNT_W     = $clog2(TURNAROUND_CYC + 2);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TURNAROUND_CYC);

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]       idx_q,      idx_d;
    logic [7:0]       crc_q,      crc_d;
    logic [23:0]      pos_q, turn_q;
    logic [7:0]       sf_q, alm_q;
    logic             drop_q;

    logic             accept;
    logic [7:0]       cf;
    logic [3:0]       id;
    logic [3:0]       len;
    logic [7:0]       tx_byte;
    logic             sending, xfer, last;
    slot_e            slot;

    tawa_cf_decode u_cf_decode (
        .clk            (clk),
        .rst            (rst),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .idle_i         (state_q == S_IDLE),
        .accept_o       (accept),
        .cf_o           (cf),
        .id_o           (id),
        .len_o          (len),
        .req_err_o      (req_err),
        .cmd_pos_rst_o  (cmd_pos_rst),
        .cmd_turn_rst_o (cmd_turn_rst),
        .cmd_err_rst_o  (cmd_err_rst)
    );

    assign sending = (state_q == S_SEND);
    assign xfer    = sending && tx_ready;
    assign last    = (idx_q == len - 4'd1);
    assign slot    = slot_of(id, idx_q);

    // Select the field for the current byte position
    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
        tx_byte = 8'h00;
        case (slot)
            SLOT_CF:   tx_byte = cf;
            SLOT_SF:   tx_byte = sf_q;
            SLOT_ABS0: tx_byte = pos_q[7:0];
            SLOT_ABS1: tx_byte = pos_q[15:8];
            SLOT_ABS2: tx_byte = pos_q[23:16];
            SLOT_ENID: tx_byte = ENID_VAL;
            SLOT_ABM0: tx_byte = turn_q[7:0];
            SLOT_ABM1: tx_byte = turn_q[15:8];
            SLOT_ABM2: tx_byte = turn_q[23:16];
            SLOT_ALMF: tx_byte = alm_q;
            SLOT_CRC:  tx_byte = crc_q;
            default:   tx_byte = 8'h00;
        endcase
    end

    // Frame sequencing: IDLE -> WAIT (turnaround) -> SEND until the CRC byte transfers
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                    idx_d      = 4'd0;
                    crc_d      = 8'h00;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                        crc_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        crc_d = crc_q ^ tx_byte;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; drop flags a request arriving mid-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            idx_q      <= 4'd0;
            crc_q      <= 8'h00;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            drop_q     <= rx_valid && (state_q != S_IDLE);
        end
    end

    // Snapshot of the encoder fields, frozen for the whole reply
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is ordinary flops, not a RAM, so it is cleared by reset like the control state.
        if (rst) begin
            pos_q  <= 24'h0;
            turn_q <= 24'h0;
            sf_q   <= 8'h00;
            alm_q  <= 8'h00;
        end else if (accept) begin
            pos_q  <= pos_in;
            turn_q <= turn_in;
            sf_q   <= sf_in;
            alm_q  <= alm_in;
        end
    end

    assign tx_valid   = sending;
    assign tx_data    = sending ? tx_byte : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign drop       = drop_q;
    assign frame_done = xfer && last;

endmodule

// File: tb/tb_tawa_encoder_responder.sv
// Directed bench for the T-format responder (turnaround set to 0).
module tb_tawa_encoder_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] pos_in, turn_in;
    logic [7:0]  sf_in, alm_in;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, req_err, drop;
    logic        cmd_pos_rst, cmd_turn_rst, cmd_err_rst, frame_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got [0:15];
    int         got_n, fd_cnt, fd_on_last, drop_cnt, first_valid;
    int         stall_cycles, stall_changed, stall_valid_and;
    logic [7:0] stall_data;

    always #5 clk = ~clk;

    tawa_encoder_responder #(
        .TURNAROUND_CYC (0),
        .ENID_VAL       (8'h17)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .pos_in       (pos_in),
        .turn_in      (turn_in),
        .sf_in        (sf_in),
        .alm_in       (alm_in),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .busy         (busy),
        .req_err      (req_err),
        .drop         (drop),
        .cmd_pos_rst  (cmd_pos_rst),
        .cmd_turn_rst (cmd_turn_rst),
        .cmd_err_rst  (cmd_err_rst),
        .frame_done   (frame_done)
    );

    // Present one request byte; returns #1 into the cycle after the strobe.
    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
    endtask

    // Accept up to n bytes (bounded), optionally stalling and injecting a request.
    task automatic collect(input int n, input int stall_at, input int stall_len, input int inject_at);
        int  left;
        bit  injected;
        left = stall_len;
        injected = 1'b0;
        got_n = 0; fd_cnt = 0; fd_on_last = 0; drop_cnt = 0; first_valid = -1;
        stall_cycles = 0; stall_changed = 0; stall_valid_and = 1; stall_data = 8'h00;
        for (int cyc = 0; cyc < 200 && got_n < n; cyc++) begin
            if (inject_at >= 0 && !injected && got_n == inject_at) begin
                rx_data  = 8'h02;
                rx_valid = 1'b1;
                injected = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            if (got_n == stall_at && left > 0) begin
                tx_ready = 1'b0;
                left--;
            end else begin
                tx_ready = 1'b1;
            end
            #1;
            if (drop) drop_cnt++;
            if (frame_done) fd_cnt++;
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (!tx_ready && got_n == stall_at) begin
                if (stall_cycles == 0) stall_data = tx_data;
                else if (tx_data !== stall_data) stall_changed = 1;
                if (tx_valid !== 1'b1) stall_valid_and = 0;
                stall_cycles++;
            end
            if (tx_valid && tx_ready) begin
                got[got_n] = tx_data;
                if (frame_done && got_n == n - 1) fd_on_last = 1;
                got_n++;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({tx_data, tx_valid, busy, req_err, drop, cmd_pos_rst, cmd_turn_rst, cmd_err_rst, frame_done} !== 16'h0000)
            begin failures++; $display("FAIL reset_outputs: got %h want 0000",
                {tx_data, tx_valid, busy, req_err, drop, cmd_pos_rst, cmd_turn_rst, cmd_err_rst, frame_done}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_id0();
        logic [7:0] exp_b [0:5];
        exp_b = '{8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h72};
        pos_in = 24'h123456; sf_in = 8'h00;
        send_req(8'h02);
        checks++;
        if (busy !== 1'b1 || req_err !== 1'b0) begin failures++; $display("FAIL id0_accept: busy=%b req_err=%b want busy=1 req_err=0", busy, req_err); end
        checks++;
        if ({cmd_pos_rst, cmd_turn_rst, cmd_err_rst} !== 3'b000) begin failures++; $display("FAIL id0_no_cmd: got %b want 000", {cmd_pos_rst, cmd_turn_rst, cmd_err_rst}); end
        collect(6, -1, 0, -1);
        checks++;
        if (got_n !== 6) begin failures++; $display("FAIL id0_len: got %0d bytes want 6", got_n); end
        checks++;
        if (first_valid !== 1) begin failures++; $display("FAIL id0_latency: first tx_valid at %0d want 1", first_valid); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL id0_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++;
        if (fd_cnt !== 1 || fd_on_last !== 1) begin failures++; $display("FAIL id0_frame_done: count=%0d on_last=%0d want 1/1", fd_cnt, fd_on_last); end
        tx_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || frame_done !== 1'b0)
            begin failures++; $display("FAIL id0_after: busy=%b tx_valid=%b frame_done=%b want 0", busy, tx_valid, frame_done); end
    endtask

    task automatic test_id2();
        logic [7:0] exp_b [0:3];
        exp_b = '{8'h92, 8'h00, 8'h17, 8'h85};
        sf_in = 8'h00;
        send_req(8'h92);
        collect(4, -1, 0, -1);
        checks++;
        if (got_n !== 4) begin failures++; $display("FAIL id2_len: got %0d bytes want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL id2_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        tx_ready = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL id2_end: tx_valid=%b busy=%b want 0", tx_valid, busy); end
    endtask

    // ID3 with inputs scrambled right after the request: the snapshot must win.
    task automatic test_id3_snapshot();
        logic [7:0] exp_b [0:10];
        // CRC = 1A^00^01^00^00^17^02^00^00^00 = 0E
        exp_b = '{8'h1A, 8'h00, 8'h01, 8'h00, 8'h00, 8'h17, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0E};
        pos_in = 24'h000001; turn_in = 24'h000002; alm_in = 8'h00; sf_in = 8'h00;
        send_req(8'h1A);
        pos_in = 24'hFFFFFF; turn_in = 24'hABCDEF; alm_in = 8'hAA; sf_in = 8'h55;
        collect(11, -1, 0, -1);
        checks++;
        if (got_n !== 11) begin failures++; $display("FAIL id3_len: got %0d bytes want 11", got_n); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL id3_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++;
        if (fd_cnt !== 1) begin failures++; $display("FAIL id3_frame_done: count=%0d want 1", fd_cnt); end
        tx_ready = 1'b0;
        sf_in = 8'h00; pos_in = 24'h0; turn_in = 24'h0; alm_in = 8'h00;
    endtask

    task automatic test_req_err();
        logic [7:0] bad [0:1];
        logic [7:0] exp_b [0:5];
        bad   = '{8'h0A, 8'h2A};
        exp_b = '{8'h8A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h8F};
        sf_in = 8'h00; turn_in = 24'h000005;
        for (int k = 0; k < 2; k++) begin
            send_req(bad[k]);
            checks++;
            if (req_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL req_err_%h: req_err=%b busy=%b want 1/0", bad[k], req_err, busy); end
            @(negedge clk);
            #1;
            checks++;
            if (req_err !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL req_err_%h_after: req_err=%b tx_valid=%b want 0/0", bad[k], req_err, tx_valid); end
        end
        send_req(8'h8A);
        checks++;
        if (req_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL id1_accept: req_err=%b busy=%b want 0/1", req_err, busy); end
        collect(6, -1, 0, -1);
        checks++;
        if (got_n !== 6) begin failures++; $display("FAIL id1_len: got %0d bytes want 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL id1_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_stall_drop();
        logic [7:0] exp_b [0:5];
        exp_b = '{8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h72};
        pos_in = 24'h123456; sf_in = 8'h00;
        send_req(8'h02);
        collect(6, 3, 5, 1);
        checks++;
        if (got_n !== 6) begin failures++; $display("FAIL stall_len: got %0d bytes want 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL stall_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++;
        if (stall_cycles !== 5 || stall_data !== 8'h34 || stall_changed !== 0 || stall_valid_and !== 1)
            begin failures++; $display("FAIL stall_hold: cycles=%0d data=%h changed=%0d valid=%0d want 5/34/0/1",
                stall_cycles, stall_data, stall_changed, stall_valid_and); end
        checks++;
        if (drop_cnt !== 1) begin failures++; $display("FAIL drop_pulse: count=%0d want 1", drop_cnt); end
        checks++;
        if (fd_cnt !== 1) begin failures++; $display("FAIL stall_frame_done: count=%0d want 1", fd_cnt); end
        tx_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL stall_end: busy=%b tx_valid=%b want 0 (dropped request must not start a frame)", busy, tx_valid); end
    endtask

    task automatic test_cmds();
        logic [7:0] cfs  [0:2];
        logic [2:0] cmds [0:2];
        logic [7:0] crcs [0:2];
        cfs  = '{8'hBA, 8'hC2, 8'h62};
        cmds = '{3'b100, 3'b010, 3'b001};
        crcs = '{8'hCA, 8'hB2, 8'h12};
        pos_in = 24'h123456; sf_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            send_req(cfs[k]);
            checks++;
            if ({cmd_pos_rst, cmd_turn_rst, cmd_err_rst} !== cmds[k])
                begin failures++; $display("FAIL cmd_%h: got %b want %b", cfs[k], {cmd_pos_rst, cmd_turn_rst, cmd_err_rst}, cmds[k]); end
            @(negedge clk);
            #1;
            checks++;
            if ({cmd_pos_rst, cmd_turn_rst, cmd_err_rst} !== 3'b000)
                begin failures++; $display("FAIL cmd_%h_single: got %b want 000", cfs[k], {cmd_pos_rst, cmd_turn_rst, cmd_err_rst}); end
            collect(6, -1, 0, -1);
            checks++;
            if (got_n !== 6 || got[0] !== cfs[k] || got[5] !== crcs[k])
                begin failures++; $display("FAIL cmd_%h_frame: n=%0d cf=%h crc=%h want 6/%h/%h", cfs[k], got_n, got[0], got[5], cfs[k], crcs[k]); end
            tx_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b [0:5];
        exp_b = '{8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h72};
        pos_in = 24'h000001; turn_in = 24'h000002; alm_in = 8'h00; sf_in = 8'h00;
        send_req(8'h1A);
        collect(2, -1, 0, -1);
        tx_ready = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin failures++; $display("FAIL midframe_byte2: tx_valid=%b tx_data=%h want 1/01", tx_valid, tx_data); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00)
            begin failures++; $display("FAIL midframe_reset: tx_valid=%b busy=%b tx_data=%h want 0/0/00", tx_valid, busy, tx_data); end
        rst = 1'b0;
        pos_in = 24'h123456;
        send_req(8'h02);
        collect(6, -1, 0, -1);
        checks++;
        if (got_n !== 6) begin failures++; $display("FAIL post_reset_len: got %0d bytes want 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin failures++; $display("FAIL post_reset_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        pos_in = 24'h0; turn_in = 24'h0; sf_in = 8'h00; alm_in = 8'h00;
        test_reset();
        test_id0();
        test_id2();
        test_id3_snapshot();
        test_req_err();
        test_stall_drop();
        test_cmds();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
